// File: rtl/roller_pkg.sv
// roller_pkg
//   Shared types and constants for the rand_roller display path.
//   - roller_state_e : roll FSM states (IDLE, ROLL)
//   - roller_mode_e  : deceleration profile latched at the start of a roll
//   - DEF_TAPS       : default Galois feedback mask for the 16-bit LFSR
//   - DEF_SEED       : default non-zero LFSR seed
package roller_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ROLL = 1'b1
  } roller_state_e;

  typedef enum logic {
    DEC_LINEAR = 1'b0,
    DEC_QUAD   = 1'b1
  } roller_mode_e;

  localparam logic [15:0] DEF_TAPS = 16'hB400;
  localparam logic [15:0] DEF_SEED = 16'hACE1;

endpackage

// File: rtl/lfsr_galois.sv
// lfsr_galois
//   Right-shifting Galois LFSR that advances every clock cycle.
//   Ports:
//     i_clk    in   clock
//     i_rst_n  in   asynchronous active-low reset, loads SEED
//     i_load   in   load i_seed instead of advancing this cycle
//     i_seed   in   [WIDTH] seed value; zero is replaced by SEED
//     o_state  out  [WIDTH] current register contents
module lfsr_galois
  import roller_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_seed,
  output logic [WIDTH-1:0] o_state
);

  logic [WIDTH-1:0] state_r;
  logic [WIDTH-1:0] state_w;

  // An all-zero state would lock the LFSR, so a zero seed falls back to SEED.
  always_comb begin
    state_w = state_r >> 1;
    if (i_load) begin
      state_w = (i_seed == '0) ? SEED : i_seed;
    end else if (state_r[0]) begin
      state_w = (state_r >> 1) ^ TAPS;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r <= SEED;
    end else begin
      state_r <= state_w;
    end
  end

  assign o_state = state_r;

endmodule

// File: rtl/rand_roller.sv
// rand_roller
//   Slot-machine style roller: on start it shows STEPS pseudo-random values
//   whose update interval grows linearly or quadratically, then settles,
//   pulses o_done and pushes the final value into a small history.
//   Ports:
//     i_clk         in   clock
//     i_rst_n       in   asynchronous active-low reset
//     i_start       in   start / restart request (level, sampled each cycle)
//     i_stop        in   freeze the current roll at its displayed value
//     i_mode        in   0 = linear, 1 = quadratic deceleration
//     i_seed_load   in   load i_seed into the LFSR
//     i_seed        in   [LFSR_W] seed value
//     o_random_out  out  [WIDTH] displayed value
//     o_busy        out  roll in progress
//     o_done        out  one-cycle pulse after a roll ends
//     o_hist        out  [HIST_DEPTH*WIDTH] final results, slice 0 newest
module rand_roller
  import roller_pkg::*;
#(
  parameter int                WIDTH      = 4,
  parameter int                LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS  = LFSR_W'(DEF_TAPS),
  parameter logic [LFSR_W-1:0] SEED       = LFSR_W'(DEF_SEED),
  parameter int                STEPS      = 24,
  parameter int                BASE_DELAY = 1024,
  parameter int                HIST_DEPTH = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  input  logic                        i_stop,
  input  logic                        i_mode,
  input  logic                        i_seed_load,
  input  logic [LFSR_W-1:0]           i_seed,
  output logic [WIDTH-1:0]            o_random_out,
  output logic                        o_busy,
  output logic                        o_done,
  output logic [HIST_DEPTH*WIDTH-1:0] o_hist
);

  localparam int CNT_W  = $clog2(BASE_DELAY * STEPS * STEPS + 1);
  localparam int STEP_W = $clog2(STEPS + 1);

  roller_state_e               state_r, state_w;
  roller_mode_e                mode_r, mode_w;
  logic [STEP_W-1:0]           step_r, step_w;
  logic [CNT_W-1:0]            wait_r, wait_w;
  logic [WIDTH-1:0]            value_r, value_w;
  logic                        done_pend_r, done_pend_w;
  logic                        done_r;
  logic [HIST_DEPTH*WIDTH-1:0] hist_r, hist_w;

  logic [LFSR_W-1:0] lfsr_state;
  logic [WIDTH-1:0]  sample_w;
  logic [CNT_W-1:0]  interval_w;
  logic              push_w;
  logic [WIDTH-1:0]  push_val_w;
  logic              unused_lfsr_hi;

  lfsr_galois #(
    .WIDTH (LFSR_W),
    .TAPS  (LFSR_TAPS),
    .SEED  (SEED)
  ) u_lfsr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (i_seed_load),
    .i_seed  (i_seed),
    .o_state (lfsr_state)
  );

  // Only the low bits are displayed; the upper bits just keep the sequence long.
  assign sample_w       = lfsr_state[WIDTH-1:0];
  assign unused_lfsr_hi = ^(lfsr_state >> WIDTH);

  // Cycles spent showing update number step_r before the next one.
  always_comb begin
    interval_w = CNT_W'(BASE_DELAY) * CNT_W'(step_r);
    if (mode_r == DEC_QUAD) begin
      interval_w = interval_w * CNT_W'(step_r);
    end
  end

  // Start (or restart) wins over stop; stop wins over a coincident update so
  // the frozen value is exactly what was on display.
  always_comb begin
    state_w     = state_r;
    mode_w      = mode_r;
    step_w      = step_r;
    wait_w      = wait_r;
    value_w     = value_r;
    done_pend_w = 1'b0;
    push_w      = 1'b0;
    push_val_w  = value_r;
    if (i_start) begin
      value_w = sample_w;
      step_w  = STEP_W'(1);
      wait_w  = '0;
      mode_w  = roller_mode_e'(i_mode);
      state_w = ROLL;
    end else if (state_r == ROLL) begin
      if (i_stop) begin
        state_w     = IDLE;
        done_pend_w = 1'b1;
        push_w      = 1'b1;
      end else if (wait_r == interval_w - CNT_W'(1)) begin
        value_w = sample_w;
        step_w  = step_r + STEP_W'(1);
        wait_w  = '0;
        if (step_r == STEP_W'(STEPS - 1)) begin
          state_w     = IDLE;
          done_pend_w = 1'b1;
          push_w      = 1'b1;
          push_val_w  = sample_w;
        end
      end else begin
        wait_w = wait_r + CNT_W'(1);
      end
    end
  end

  // History shift: older entries move up one slice, the oldest falls off.
  always_comb begin
    hist_w = hist_r;
    if (push_w) begin
      for (int i = HIST_DEPTH - 1; i > 0; i--) begin
        hist_w[i*WIDTH +: WIDTH] = hist_r[(i-1)*WIDTH +: WIDTH];
      end
      hist_w[0 +: WIDTH] = push_val_w;
    end
  end

  // done_pend_r marks the ending edge; o_done follows it one cycle later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= IDLE;
      mode_r      <= DEC_LINEAR;
      step_r      <= '0;
      wait_r      <= '0;
      value_r     <= '0;
      done_pend_r <= 1'b0;
      done_r      <= 1'b0;
      hist_r      <= '0;
    end else begin
      state_r     <= state_w;
      mode_r      <= mode_w;
      step_r      <= step_w;
      wait_r      <= wait_w;
      value_r     <= value_w;
      done_pend_r <= done_pend_w;
      done_r      <= done_pend_r;
      hist_r      <= hist_w;
    end
  end

  assign o_random_out = value_r;
  assign o_busy       = (state_r == ROLL);
  assign o_done       = done_r;
  assign o_hist       = hist_r;

endmodule

// File: tb/tb_rand_roller.sv
// tb_rand_roller
//   Table-driven bench for rand_roller with WIDTH=4, STEPS=4, BASE_DELAY=2,
//   HIST_DEPTH=2. Each vector drives one cycle of inputs and states which
//   edge takes a new sample, pushes history, and the expected busy/done.
//   Displayed values come from an independent LFSR reference model.
module tb_rand_roller;

  localparam logic [15:0] T_SEED = 16'hACE1;
  localparam logic [15:0] T_TAPS = 16'hB400;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        mode;
  logic        seed_load;
  logic [15:0] seed;
  logic [3:0]  random_out;
  logic        busy;
  logic        done;
  logic [7:0]  hist;

  int n_checks;
  int n_errors;

  typedef struct {
    logic        start;
    logic        stop;
    logic        mode;
    logic        seed_load;
    logic [15:0] seed;
    logic        upd;
    logic        push;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t        vecs[$];
  logic        roll_mode;
  logic [3:0]  exp_val;
  logic [7:0]  exp_hist;
  logic [15:0] model_lfsr;

  rand_roller #(
    .WIDTH      (4),
    .LFSR_W     (16),
    .LFSR_TAPS  (T_TAPS),
    .SEED       (T_SEED),
    .STEPS      (4),
    .BASE_DELAY (2),
    .HIST_DEPTH (2)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_stop       (stop),
    .i_mode       (mode),
    .i_seed_load  (seed_load),
    .i_seed       (seed),
    .o_random_out (random_out),
    .o_busy       (busy),
    .o_done       (done),
    .o_hist       (hist)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference Galois LFSR (right shift, mask B400).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_lfsr <= T_SEED;
    end else if (seed_load) begin
      model_lfsr <= (seed == 16'h0) ? T_SEED : seed;
    end else if (model_lfsr[0]) begin
      model_lfsr <= (model_lfsr >> 1) ^ T_TAPS;
    end else begin
      model_lfsr <= model_lfsr >> 1;
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic st, input logic sp, input logic upd,
                         input logic push, input logic bsy, input logic dn);
    vec_t v;
    v.start = st; v.stop = sp; v.mode = roll_mode; v.seed_load = 1'b0; v.seed = 16'h0;
    v.upd = upd; v.push = push; v.busy = bsy; v.done = dn;
    vecs.push_back(v);
  endtask

  task automatic add_seed(input logic [15:0] s);
    vec_t v;
    v.start = 1'b0; v.stop = 1'b0; v.mode = roll_mode; v.seed_load = 1'b1; v.seed = s;
    v.upd = 1'b0; v.push = 1'b0; v.busy = 1'b0; v.done = 1'b0;
    vecs.push_back(v);
  endtask

  task automatic add_wait(input int n);
    for (int k = 0; k < n; k++) add_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  // Linear roll after the start edge: intervals 2, 4, 6.
  task automatic add_linear_tail();
    add_wait(1); add_vec(0, 0, 1, 0, 1, 0);
    add_wait(3); add_vec(0, 0, 1, 0, 1, 0);
    add_wait(5); add_vec(0, 0, 1, 1, 0, 0);
    add_vec(0, 0, 0, 0, 0, 1);
    add_vec(0, 0, 0, 0, 0, 0);
  endtask

  task automatic add_linear_roll();
    roll_mode = 1'b0;
    add_vec(1, 0, 1, 0, 1, 0);
    add_linear_tail();
  endtask

  task automatic add_idle(input int n);
    for (int k = 0; k < n; k++) add_vec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic apply_stimulus(input string tag);
    logic [15:0] pre;
    for (int i = 0; i < vecs.size(); i++) begin
      start     = vecs[i].start;
      stop      = vecs[i].stop;
      mode      = vecs[i].mode;
      seed_load = vecs[i].seed_load;
      seed      = vecs[i].seed;
      pre       = model_lfsr;
      @(posedge clk);
      #1;
      if (vecs[i].upd)  exp_val  = pre[3:0];
      if (vecs[i].push) exp_hist = {exp_hist[3:0], exp_val};
      check_output($sformatf("%s[%0d].value", tag, i), 32'(random_out), 32'(exp_val));
      check_output($sformatf("%s[%0d].busy", tag, i), 32'(busy), 32'(vecs[i].busy));
      check_output($sformatf("%s[%0d].done", tag, i), 32'(done), 32'(vecs[i].done));
      check_output($sformatf("%s[%0d].hist", tag, i), 32'(hist), 32'(exp_hist));
    end
    vecs.delete();
    start = 1'b0; stop = 1'b0; seed_load = 1'b0; seed = 16'h0;
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    exp_val = 4'h0; exp_hist = 8'h0; roll_mode = 1'b0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0;
    seed_load = 1'b0; seed = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check_output("reset.value", 32'(random_out), 32'h0);
    check_output("reset.busy", 32'(busy), 32'h0);
    check_output("reset.done", 32'(done), 32'h0);
    check_output("reset.hist", 32'(hist), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Linear roll: updates at cycles 1, 3, 7, 13, done at 14.
    add_linear_roll();
    apply_stimulus("linear");

    // Quadratic roll: intervals 2, 8, 18.
    roll_mode = 1'b1;
    add_vec(1, 0, 1, 0, 1, 0);
    add_wait(1);  add_vec(0, 0, 1, 0, 1, 0);
    add_wait(7);  add_vec(0, 0, 1, 0, 1, 0);
    add_wait(17); add_vec(0, 0, 1, 1, 0, 0);
    add_vec(0, 0, 0, 0, 0, 1);
    add_vec(0, 0, 0, 0, 0, 0);
    apply_stimulus("quad");

    // Stop during cycle 5 freezes update 2; stop while idle does nothing.
    roll_mode = 1'b0;
    add_vec(1, 0, 1, 0, 1, 0);
    add_wait(1); add_vec(0, 0, 1, 0, 1, 0);
    add_wait(2);
    add_vec(0, 1, 0, 1, 0, 0);
    add_vec(0, 0, 0, 0, 0, 1);
    add_vec(0, 0, 0, 0, 0, 0);
    add_vec(0, 1, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0);
    apply_stimulus("stop");

    // Restart during cycle 5, first alone then together with stop.
    for (int r = 0; r < 2; r++) begin
      add_vec(1, 0, 1, 0, 1, 0);
      add_wait(1); add_vec(0, 0, 1, 0, 1, 0);
      add_wait(2);
      add_vec(1, (r == 1), 1, 0, 1, 0);
      add_wait(1); add_vec(0, 0, 1, 0, 1, 0);
      add_wait(3); add_vec(0, 0, 1, 0, 1, 0);
      add_wait(5); add_vec(0, 0, 1, 1, 0, 0);
      add_vec(0, 0, 0, 0, 0, 1);
      add_vec(0, 0, 0, 0, 0, 0);
      apply_stimulus((r == 0) ? "restart" : "restart_stop");
    end

    // Zero seed falls back to ACE1, whose low nibble is 1.
    add_seed(16'h0000);
    add_vec(1, 0, 1, 0, 1, 0);
    apply_stimulus("seed0");
    check_output("seed0.first_sample", 32'(random_out), 32'h1);
    add_linear_tail();
    apply_stimulus("seed0_tail");

    // Seed 1234 gives a first sample of 4.
    add_seed(16'h1234);
    add_vec(1, 0, 1, 0, 1, 0);
    apply_stimulus("seed1234");
    check_output("seed1234.first_sample", 32'(random_out), 32'h4);
    add_linear_tail();
    apply_stimulus("seed1234_tail");

    // Third completed roll in a row; history keeps only the last two.
    add_linear_roll();
    apply_stimulus("hist3");
    check_output("hist.last_two", 32'(hist), 32'(exp_hist));

    // Asynchronous reset in cycle 6 of a roll.
    add_vec(1, 0, 1, 0, 1, 0);
    add_wait(1); add_vec(0, 0, 1, 0, 1, 0);
    add_wait(3);
    apply_stimulus("pre_reset");
    rst_n = 1'b0;
    #1;
    check_output("midreset.value", 32'(random_out), 32'h0);
    check_output("midreset.busy", 32'(busy), 32'h0);
    check_output("midreset.done", 32'(done), 32'h0);
    check_output("midreset.hist", 32'(hist), 32'h0);
    exp_val = 4'h0; exp_hist = 8'h0;
    #3;
    rst_n = 1'b1;
    add_idle(2);
    add_linear_roll();
    apply_stimulus("post_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
